// File: rtl/amber128_slot_sequencer.sv
// Slot sequencer: holds one fetched 128-bit bundle and walks the slot decoder through
// its ops (slot 0..4, two 12-bit halves where flagged), accepting the next bundle with no bubble.
package amber128_pkg;
  localparam int C_XLEN = 128;
  localparam int C_AW   = 32;

  typedef struct packed {
    logic              valid;
    logic [C_AW-1:0]   word_addr;
    logic [C_XLEN-1:0] bundle;
  } amber128_fetch_s;
endpackage

module amber128_slot_sequencer
  import amber128_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  amber128_fetch_s fetch_i,
  output logic            fetch_ready_o,
  output amber128_fetch_s dec_fetch_o,
  output logic [2:0]      slot_idx_o,
  output logic            sub12_o,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  input  logic            br_taken_i,
  input  logic            flush_i,
  output logic            bundle_done_o
);
  localparam int NUM_SLOTS = 5;

  // state | meaning
  // IDLE  | no bundle held, waiting for fetch
  // RUN   | bundle held, current op presented to issue
  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [C_AW-1:0]   addr_q, addr_d;
  logic [C_XLEN-1:0] bundle_q, bundle_d;
  logic [2:0]        slot_q, slot_d;
  logic              sub12_q, sub12_d;
  logic              done_q, done_d;
  logic              two12, last_op, fire, load;

  assign two12         = bundle_q[7'd127 - {4'd0, slot_q}];
  assign last_op       = (slot_q == 3'(NUM_SLOTS - 1)) & (~two12 | sub12_q);
  assign issue_valid_o = (state_q == RUN);
  assign fire          = issue_valid_o & issue_ready_i;
  // Next bundle may enter on the cycle the current one retires, giving zero bubble.
  assign fetch_ready_o = ~flush_i & ((state_q == IDLE) | (fire & (last_op | br_taken_i)));
  assign load          = fetch_i.valid & fetch_ready_o;

  always_comb begin
    dec_fetch_o           = '0;
    dec_fetch_o.valid     = (state_q == RUN);
    dec_fetch_o.word_addr = addr_q;
    dec_fetch_o.bundle    = bundle_q;
  end

  assign slot_idx_o    = slot_q;
  assign sub12_o       = sub12_q;
  assign bundle_done_o = done_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bundle_d = bundle_q;
    slot_d   = slot_q;
    sub12_d  = sub12_q;
    done_d   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      slot_d  = '0;
      sub12_d = 1'b0;
    end else begin
      if (fire) begin
        if (last_op | br_taken_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (two12 & ~sub12_q) begin
          sub12_d = 1'b1;
        end else begin
          sub12_d = 1'b0;
          slot_d  = slot_q + 3'd1;
        end
      end
      if (load) begin
        state_d  = RUN;
        addr_d   = fetch_i.word_addr;
        bundle_d = fetch_i.bundle;
        slot_d   = '0;
        sub12_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      bundle_q <= '0;
      slot_q   <= '0;
      sub12_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bundle_q <= bundle_d;
      slot_q   <= slot_d;
      sub12_q  <= sub12_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_amber128_slot_sequencer.sv
// Bench for amber128_slot_sequencer: op-queue reference model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_amber128_slot_sequencer;
  import amber128_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  amber128_fetch_s fetch, dec;
  logic            fetch_ready, issue_valid, issue_ready, br, flush, done;
  logic [2:0]      slot;
  logic            sub12;

  amber128_slot_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_i(fetch), .fetch_ready_o(fetch_ready),
    .dec_fetch_o(dec), .slot_idx_o(slot), .sub12_o(sub12), .issue_valid_o(issue_valid),
    .issue_ready_i(issue_ready), .br_taken_i(br), .flush_i(flush), .bundle_done_o(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: the ops still to issue from the held bundle, in order, as {slot, sub}.
  logic [3:0]        m_ops[$];
  logic [31:0]       m_addr;
  logic [127:0]      m_bundle;
  logic              m_done;

  logic [3:0]        fired[$];
  int                done_cnt;
  logic              acc;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_bundle(input logic [4:0] flags, input logic [31:0] seed);
    return {flags, seed, ~seed, seed ^ 32'hA5A5_A5A5, seed[26:0]};
  endfunction

  task automatic model_reset();
    m_ops.delete();
    m_addr   = '0;
    m_bundle = '0;
    m_done   = 1'b0;
  endtask

  task automatic model_load(input logic [31:0] a, input logic [127:0] b);
    logic [4:0] fl;
    m_ops.delete();
    m_addr   = a;
    m_bundle = b;
    fl       = b[127:123];
    for (int k = 0; k < 5; k++) begin
      m_ops.push_back({3'(k), 1'b0});
      if (fl[4-k]) m_ops.push_back({3'(k), 1'b1});
    end
  endtask

  task automatic tick();
    logic busy, exp_fr, fire_m, nd;
    #1;
    if (!rst_n) model_reset();
    busy   = (m_ops.size() != 0);
    exp_fr = !flush && (!busy || (issue_ready && (m_ops.size() == 1 || br)));
    chk("issue_valid", 160'(issue_valid), 160'(busy));
    if (busy) begin
      chk("slot_idx", 160'(slot), 160'(m_ops[0][3:1]));
      chk("sub12", 160'(sub12), 160'(m_ops[0][0]));
    end
    chk("dec_valid", 160'(dec.valid), 160'(busy));
    chk("word_addr", 160'(dec.word_addr), 160'(m_addr));
    chk("bundle", 160'(dec.bundle), 160'(m_bundle));
    chk("bundle_done", 160'(done), 160'(m_done));
    chk("fetch_ready", 160'(fetch_ready), 160'(exp_fr));
    if (issue_valid && issue_ready) fired.push_back({slot, sub12});
    if (done) done_cnt++;
    acc = fetch.valid & fetch_ready;
    if (rst_n) begin
      fire_m = busy && issue_ready;
      nd     = 1'b0;
      if (flush) begin
        m_ops.delete();
      end else begin
        if (fire_m) begin
          void'(m_ops.pop_front());
          if (br || m_ops.size() == 0) begin
            m_ops.delete();
            nd = 1'b1;
          end
        end
        if (fetch.valid && exp_fr) model_load(fetch.word_addr, fetch.bundle);
      end
      m_done = nd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_scn();
    fired.delete();
    done_cnt = 0;
  endtask

  task automatic offer(input logic [31:0] a, input logic [4:0] flags);
    fetch.valid     = 1'b1;
    fetch.word_addr = a;
    fetch.bundle    = mk_bundle(flags, a * 32'h9E37_79B9);
  endtask

  initial begin
    int n;
    logic [3:0] exp8[8];
    exp8 = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    rst_n = 1'b0; fetch = '0; issue_ready = 1'b1; br = 1'b0; flush = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset values
    tick();
    chk("rst_issue_valid", 160'(issue_valid), 160'd0);
    chk("rst_dec", 160'(dec), 160'd0);
    chk("rst_fetch_ready", 160'(fetch_ready), 160'd1);
    rst_n = 1'b1;
    tick();

    // Flags 00000: five single ops
    start_scn();
    offer(32'h100, 5'b00000); tick(); fetch.valid = 1'b0;
    repeat (7) tick();
    chk("s1_ops", 160'(fired.size()), 160'd5);
    for (int k = 0; k < 5; k++) chk("s1_seq", 160'(fired[k]), 160'({3'(k), 1'b0}));
    chk("s1_done", 160'(done_cnt), 160'd1);

    // Flags 10101: eight ops
    start_scn();
    offer(32'h180, 5'b10101); tick(); fetch.valid = 1'b0;
    repeat (10) tick();
    chk("s2_ops", 160'(fired.size()), 160'd8);
    for (int k = 0; k < 8; k++) chk("s2_seq", 160'(fired[k]), 160'(exp8[k]));

    // Back-to-back bundles with fetch valid held high
    start_scn();
    offer(32'h200, 5'b01000);
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin tick(); n++; end
    chk("s3_first_accept", 160'(n), 160'd1);
    offer(32'h300, 5'b00001);
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin tick(); n++; end
    chk("s3_gap", 160'(n), 160'd6);
    fetch.valid = 1'b0;
    chk("s3_next_first", 160'({issue_valid, slot, sub12, dec.word_addr}), 160'({1'b1, 3'd0, 1'b0, 32'h300}));
    repeat (8) tick();
    chk("s3_ops", 160'(fired.size()), 160'd12);
    chk("s3_done", 160'(done_cnt), 160'd2);

    // Stall at (2,1)
    start_scn();
    offer(32'h400, 5'b00100); tick(); fetch.valid = 1'b0;
    repeat (3) tick();
    issue_ready = 1'b0;
    offer(32'h480, 5'b00000);
    repeat (3) begin
      tick();
      chk("s4_hold", 160'({slot, sub12, issue_valid, fetch_ready}), 160'({3'd2, 1'b1, 1'b1, 1'b0}));
    end
    issue_ready = 1'b1;
    repeat (3) tick();
    fetch.valid = 1'b0;
    repeat (7) tick();
    chk("s4_resume", 160'(fired[3]), 160'h5);
    chk("s4_ops", 160'(fired.size()), 160'd11);

    // Branch taken at (1,0) with same-cycle load
    start_scn();
    offer(32'h500, 5'b00000); tick(); fetch.valid = 1'b0;
    tick();
    br = 1'b1; offer(32'h600, 5'b11111);
    tick();
    br = 1'b0; fetch.valid = 1'b0;
    chk("s5_after_br", 160'({issue_valid, slot, sub12, done, dec.word_addr}),
        160'({1'b1, 3'd0, 1'b0, 1'b1, 32'h600}));
    repeat (12) tick();
    chk("s5_ops", 160'(fired.size()), 160'd12);
    chk("s5_squash", 160'(fired[2]), 160'h0);
    chk("s5_done", 160'(done_cnt), 160'd2);

    // Flush at (3,0) with a competing fetch
    start_scn();
    offer(32'h700, 5'b00000); tick(); fetch.valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1; offer(32'h780, 5'b00000);
    tick();
    flush = 1'b0; fetch.valid = 1'b0;
    chk("s6_after_flush", 160'({issue_valid, dec.valid, done, dec.word_addr}),
        160'({1'b0, 1'b0, 1'b0, 32'h700}));
    repeat (3) tick();
    chk("s6_done", 160'(done_cnt), 160'd0);
    chk("s6_ops", 160'(fired.size()), 160'd4);

    // Reset asserted mid-RUN
    start_scn();
    offer(32'h800, 5'b10000); tick(); fetch.valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("s7_reset", 160'({issue_valid, done, slot, sub12, dec.word_addr}), 160'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
